// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display driver.
//   - Segment patterns {g,f,e,d,c,b,a}, active-low.
//   - Conversion FSM state encoding.
//   - Scan digit-index constants (index 0 is the rightmost digit).
//   - seg_encode(): maps a BCD digit to its segment pattern.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_e;

  localparam logic [1:0] DIG_ONES     = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_SIGN     = 2'd3;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3,
// one bit per clock) with optional two's-complement input.
//   clk, clear_n       : clock, async active-low reset
//   load               : start conversion (ignored while busy)
//   value, signed_mode : operand, sampled with load
//   busy               : high for the 8 conversion cycles
//   done               : commit strobe, high during the last conversion cycle
//   hundreds/tens/ones : result, valid while done is high
//   neg                : sign of the operand being converted
module bin_to_bcd_seq
  import seven_seg_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       neg
);

  conv_state_e r_state;
  logic [2:0]  r_cnt;
  logic [7:0]  r_mag;
  logic [11:0] r_bcd;
  logic        r_neg;
  logic        r_busy;

  logic [11:0] w_adj;
  logic [11:0] w_bcd_nxt;
  logic [7:0]  w_mag_nxt;

  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < 3; n++)
      if (r_bcd[n*4 +: 4] >= 4'd5) w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    {w_bcd_nxt, w_mag_nxt} = {w_adj[10:0], r_mag, 1'b0};
  end

  // done and the result are taken from the next-state value so the parent
  // can latch the finished number on the same edge the FSM leaves CONV.
  assign done     = (r_state == ST_CONV) && (r_cnt == 3'd7);
  assign hundreds = w_bcd_nxt[11:8];
  assign tens     = w_bcd_nxt[7:4];
  assign ones     = w_bcd_nxt[3:0];
  assign neg      = r_neg;
  assign busy     = r_busy;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_mag   <= 8'd0;
      r_bcd   <= 12'd0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (load) begin
          // 8'h80 negates to itself, which read unsigned is the wanted 128.
          r_mag   <= (signed_mode && value[7]) ? (~value + 8'd1) : value;
          r_neg   <= signed_mode && value[7];
          r_bcd   <= 12'd0;
          r_cnt   <= 3'd0;
          r_busy  <= 1'b1;
          r_state <= ST_CONV;
        end
        ST_CONV: begin
          r_bcd <= w_bcd_nxt;
          r_mag <= w_mag_nxt;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_driver.sv
// 4-digit multiplexed seven-segment driver for an 8-bit value shown in
// decimal, optionally signed, with optional leading-zero blanking.
//   clk, clear_n       : clock, async active-low reset
//   load               : capture value/signed_mode and convert (when !busy)
//   value, signed_mode : operand
//   busy               : conversion in progress
//   seg                : {g,f,e,d,c,b,a}, active-low
//   an                 : digit enables, active-low one-hot, an[0] rightmost
module seven_seg_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic       w_done, w_neg;
  logic [3:0] w_hun, w_ten, w_one;

  bin_to_bcd_seq u_conv (
    .clk         (clk),
    .clear_n     (clear_n),
    .load        (load),
    .value       (value),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (w_done),
    .hundreds    (w_hun),
    .tens        (w_ten),
    .ones        (w_one),
    .neg         (w_neg)
  );

  logic [3:0]    r_hun, r_ten, r_one;
  logic          r_neg;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic [6:0] w_seg_nxt;
  logic [3:0] w_an_nxt;

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = ~(4'b0001 << r_idx);
    case (r_idx)
      DIG_ONES:     w_seg_nxt = seg_encode(r_one);
      DIG_TENS:     w_seg_nxt = (BLANK_LEADING && r_hun == 4'd0 && r_ten == 4'd0)
                                ? SEG_BLANK : seg_encode(r_ten);
      DIG_HUNDREDS: w_seg_nxt = (BLANK_LEADING && r_hun == 4'd0)
                                ? SEG_BLANK : seg_encode(r_hun);
      DIG_SIGN:     w_seg_nxt = r_neg ? SEG_MINUS : SEG_BLANK;
      default:      w_seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_hun   <= 4'd0;
      r_ten   <= 4'd0;
      r_one   <= 4'd0;
      r_neg   <= 1'b0;
      r_presc <= '0;
      r_idx   <= DIG_ONES;
      r_seg   <= SEG_0;
      r_an    <= 4'b1110;
    end else begin
      if (w_done) begin
        r_hun <= w_hun;
        r_ten <= w_ten;
        r_one <= w_one;
        r_neg <= w_neg;
      end
      if (r_presc == PW'(REFRESH_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seven_seg_driver.sv
module tb_seven_seg_driver;

  logic       clk = 1'b0;
  logic       clear_n, load, signed_mode;
  logic [7:0] value;
  logic       busy_a, busy_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;

  always #5 clk = ~clk;

  seven_seg_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .clear_n(clear_n), .load(load), .value(value),
    .signed_mode(signed_mode), .busy(busy_a), .seg(seg_a), .an(an_a));

  seven_seg_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .clear_n(clear_n), .load(load), .value(value),
    .signed_mode(signed_mode), .busy(busy_b), .seg(seg_b), .an(an_b));

  int n_chk = 0, n_fail = 0;
  int cur_v = 0;
  bit cur_s = 1'b0;

  logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pattern of one digit, straight from the decimal rendering.
  function automatic logic [6:0] ref_seg(input int dig, input int v, input bit sgn, input bit blank);
    bit ng;
    int mag, h, t, o;
    ng  = sgn && (v >= 128);
    mag = ng ? 256 - v : v;
    h = mag / 100; t = (mag / 10) % 10; o = mag % 10;
    case (dig)
      0:       return segtab[o];
      1:       return (blank && h == 0 && t == 0) ? 7'b1111111 : segtab[t];
      2:       return (blank && h == 0) ? 7'b1111111 : segtab[h];
      default: return ng ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Watch 24 cycles of scanning: one-hot enable, rotation order, dwell
  // time, and segment content against the model for both blanking modes.
  task automatic scan_check(input string tag);
    logic [3:0] prev;
    int run, idx;
    bit seen;
    prev = an_a; run = 0; seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      case (an_a)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      check({tag, " an_onehot"}, 32'(idx >= 0), 32'd1);
      check({tag, " an_b"}, 32'(an_b), 32'(an_a));
      if (idx >= 0) begin
        check({tag, " seg_blank"}, 32'(seg_a), 32'(ref_seg(idx, cur_v, cur_s, 1'b1)));
        check({tag, " seg_noblank"}, 32'(seg_b), 32'(ref_seg(idx, cur_v, cur_s, 1'b0)));
      end
      if (an_a != prev) begin
        check({tag, " rotate"}, 32'(an_a), 32'({prev[2:0], prev[3]}));
        if (seen) check({tag, " dwell"}, run, 4);
        seen = 1'b1;
        run  = 1;
      end else begin
        run++;
      end
      prev = an_a;
    end
  endtask

  task automatic do_load(input int v, input bit s, input string tag);
    int cnt;
    @(negedge clk);
    load = 1'b1; value = 8'(v); signed_mode = s;
    @(posedge clk); #1 load = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_a) cnt++;
      else break;
    end
    check({tag, " busy_len"}, cnt, 8);
    cur_v = v; cur_s = s;
    repeat (2) @(negedge clk);
    scan_check(tag);
  endtask

  initial begin
    clear_n = 1'b0; load = 1'b0; value = 8'd0; signed_mode = 1'b0;
    #12;
    check("rst an", 32'(an_a), 32'h e);
    check("rst seg", 32'(seg_a), 32'h40);
    check("rst busy", 32'(busy_a), 32'd0);
    @(negedge clk) clear_n = 1'b1;
    scan_check("after_reset");

    do_load(213, 1'b0, "u213");
    do_load(8'hFF, 1'b1, "s_ff");
    do_load(8'hFF, 1'b0, "u_ff");
    do_load(8'h80, 1'b1, "s_80");
    do_load(8'h80, 1'b0, "u_80");
    do_load(0, 1'b0, "zero");
    do_load(5, 1'b0, "five");
    do_load(100, 1'b1, "s100");

    // Loads during conversion (cycle 3 and the commit cycle) are ignored.
    @(negedge clk);
    load = 1'b1; value = 8'd7; signed_mode = 1'b0;
    @(posedge clk); #1 load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; value = 8'd9;
    @(posedge clk); #1 load = 1'b0;
    check("ign busy_mid", 32'(busy_a), 32'd1);
    repeat (5) @(negedge clk);
    check("ign busy_last", 32'(busy_a), 32'd1);
    load = 1'b1; value = 8'd9;
    @(posedge clk); #1 load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ign no_reconv", 32'(busy_a), 32'd0);
    end
    cur_v = 7; cur_s = 1'b0;
    scan_check("ign shows7");
    do_load(9, 1'b0, "after_ign9");

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    load = 1'b1; value = 8'd200; signed_mode = 1'b0;
    @(posedge clk); #1 load = 1'b0;
    repeat (4) @(negedge clk);
    #1 clear_n = 1'b0;
    #1;
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort an", 32'(an_a), 32'h e);
    check("abort seg", 32'(seg_a), 32'h40);
    @(negedge clk) clear_n = 1'b1;
    cur_v = 0; cur_s = 1'b0;
    scan_check("abort nocommit");
    do_load(42, 1'b0, "after_abort");

    repeat (25) do_load(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
